// File: rtl/isp_pkg.sv
// Shared definitions for the motion-detection ISP frame scheduler:
// sequencer state encoding, default geometry and counter widths.
package isp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_RUN     = 2'd2,
    ST_REFRESH = 2'd3
  } sched_state_e;

  localparam int unsigned DEF_H_ACT = 640;
  localparam int unsigned DEF_V_ACT = 480;
  localparam int unsigned DEF_CNT_W = 20;
  localparam int unsigned GEOM_W    = 16;

  function automatic logic [GEOM_W-1:0] sat_inc(input logic [GEOM_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/isp_frame_sched_if.sv
// Frame-level strobes between the ISP chain, the frame buffer and the scheduler.
interface isp_frame_sched_if;

  logic pre_vsync;
  logic pre_href;
  logic pre_wr_en;
  logic post_vsync;
  logic post_wr_en;
  logic post_1bit;
  logic ref_wr_en;
  logic ref_rd_en;
  logic ref_bank;
  logic ref_frame_start;

  modport master (
    output pre_vsync, pre_href, pre_wr_en,
    output post_vsync, post_wr_en, post_1bit,
    input  ref_wr_en, ref_rd_en, ref_bank, ref_frame_start
  );

  modport slave (
    input  pre_vsync, pre_href, pre_wr_en,
    input  post_vsync, post_wr_en, post_1bit,
    output ref_wr_en, ref_rd_en, ref_bank, ref_frame_start
  );

endinterface

// File: rtl/isp_geom_chk.sv
// Input frame geometry checker: pixels per line and lines per frame,
// evaluated for the frame that ends at frame_evt.
module isp_geom_chk
  import isp_pkg::*;
#(
  parameter int unsigned H_ACT = DEF_H_ACT,
  parameter int unsigned V_ACT = DEF_V_ACT
) (
  input  logic clk,
  input  logic rst,
  input  logic pre_href,
  input  logic pre_wr_en,
  input  logic frame_evt,
  output logic geom_ok,
  output logic geom_armed
);

  logic              href_q, href_d;
  logic [GEOM_W-1:0] pix_q, pix_d;
  logic [GEOM_W-1:0] line_q, line_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;

  logic              href_fall;
  logic              err_now;
  logic [GEOM_W-1:0] lines_now;

  // A line ending in the same cycle as frame_evt still belongs to the closing frame.
  always_comb begin
    href_fall  = href_q & ~pre_href;
    err_now    = err_q | (href_fall & (pix_q != GEOM_W'(H_ACT)));
    lines_now  = href_fall ? sat_inc(line_q) : line_q;
    geom_ok    = ~err_now & (lines_now == GEOM_W'(V_ACT));
    geom_armed = armed_q;

    href_d = pre_href;
    pix_d  = pix_q;
    if (href_fall) begin
      pix_d = '0;
    end else if (pre_href & pre_wr_en) begin
      pix_d = sat_inc(pix_q);
    end

    line_d  = frame_evt ? '0 : lines_now;
    err_d   = frame_evt ? 1'b0 : err_now;
    armed_d = armed_q | frame_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      href_q  <= 1'b0;
      pix_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      href_q  <= href_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/isp_frame_sched.sv
// Frame sequencer for the motion-detection ISP chain: reference-buffer
// prime/read/refresh control, bank ping-pong and per-frame motion verdict.
module isp_frame_sched
  import isp_pkg::*;
#(
  parameter int unsigned H_ACT      = DEF_H_ACT,
  parameter int unsigned V_ACT      = DEF_V_ACT,
  parameter int unsigned REF_PERIOD = 8,
  parameter int unsigned MOTION_THR = 2000,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  isp_frame_sched_if.slave bus,
  output logic             diff_valid,
  output logic [CNT_W-1:0] motion_cnt,
  output logic             motion_flag,
  output logic [15:0]      frame_cnt,
  output logic             geom_err
);

  localparam int unsigned SINCE_W = $clog2(REF_PERIOD) + 1;
  localparam logic [SINCE_W-1:0] SINCE_LAST = SINCE_W'(REF_PERIOD - 1);

  sched_state_e       state_q, state_d;
  logic               bank_q, bank_d;
  logic [SINCE_W-1:0] since_q, since_d;
  logic               pre_vs_q, post_vs_q;
  logic               fs_q;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               gerr_q, gerr_d;
  logic               tag_pend_q, tag_pend_d;
  logic               tag_cur_q, tag_cur_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic               mflag_q, mflag_d;

  logic frame_evt, post_evt;
  logic geom_ok, geom_armed;
  logic wr_sel, rd_sel;

  // All frame-start updates land on the edge that registers fs, so they are visible with it.
  assign frame_evt = bus.pre_vsync & ~pre_vs_q;
  assign post_evt  = bus.post_vsync & ~post_vs_q;

  isp_geom_chk #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT)
  ) u_geom_chk (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .pre_href   (bus.pre_href),
    .pre_wr_en  (bus.pre_wr_en),
    .frame_evt  (frame_evt),
    .geom_ok    (geom_ok),
    .geom_armed (geom_armed)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      bank_q  <= 1'b0;
      since_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      since_q <= since_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    since_d = since_q;
    if (frame_evt) begin
      if (!enable) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_PRIME;
          ST_PRIME, ST_REFRESH: begin
            if (geom_ok) begin
              state_d = ST_RUN;
              bank_d  = ~bank_q;
              since_d = SINCE_W'(1);
            end
          end
          ST_RUN: begin
            if (since_q == SINCE_LAST) begin
              state_d = ST_REFRESH;
            end else begin
              since_d = since_q + 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    wr_sel = 1'b0;
    rd_sel = 1'b0;
    case (state_q)
      ST_PRIME:   wr_sel = 1'b1;
      ST_RUN:     rd_sel = 1'b1;
      ST_REFRESH: begin
        wr_sel = 1'b1;
        rd_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ref_wr_en       = wr_sel & bus.pre_wr_en;
  assign bus.ref_rd_en       = rd_sel & bus.pre_wr_en;
  assign bus.ref_bank        = bank_q;
  assign bus.ref_frame_start = fs_q;
  assign diff_valid          = rd_sel;

  // frame_cnt restarts at 1 on leaving IDLE and freezes while idle.
  always_comb begin
    fcnt_d     = fcnt_q;
    gerr_d     = gerr_q;
    tag_pend_d = tag_pend_q;
    if (frame_evt) begin
      gerr_d = geom_armed & ~geom_ok;
      if (state_d != ST_IDLE) begin
        fcnt_d = (state_q == ST_IDLE) ? 16'd1 : fcnt_q + 16'd1;
      end
    end
    if (fs_q) begin
      tag_pend_d = rd_sel;
    end
  end

  // The tag follows the chain by one post_vsync, so the verdict uses the tag of the frame just closed.
  always_comb begin
    acc_d     = acc_q;
    mcnt_d    = mcnt_q;
    mflag_d   = mflag_q;
    tag_cur_d = tag_cur_q;
    if (post_evt) begin
      mcnt_d    = acc_q;
      mflag_d   = tag_cur_q & (32'(acc_q) >= MOTION_THR);
      tag_cur_d = tag_pend_q;
      acc_d     = '0;
    end else if (bus.post_wr_en & bus.post_1bit & ~(&acc_q)) begin
      acc_d = acc_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre_vs_q   <= 1'b0;
      post_vs_q  <= 1'b0;
      fs_q       <= 1'b0;
      fcnt_q     <= '0;
      gerr_q     <= 1'b0;
      tag_pend_q <= 1'b0;
      tag_cur_q  <= 1'b0;
      acc_q      <= '0;
      mcnt_q     <= '0;
      mflag_q    <= 1'b0;
    end else begin
      pre_vs_q   <= bus.pre_vsync;
      post_vs_q  <= bus.post_vsync;
      fs_q       <= frame_evt;
      fcnt_q     <= fcnt_d;
      gerr_q     <= gerr_d;
      tag_pend_q <= tag_pend_d;
      tag_cur_q  <= tag_cur_d;
      acc_q      <= acc_d;
      mcnt_q     <= mcnt_d;
      mflag_q    <= mflag_d;
    end
  end

  assign motion_cnt  = mcnt_q;
  assign motion_flag = mflag_q;
  assign frame_cnt   = fcnt_q;
  assign geom_err    = gerr_q;

endmodule

// File: tb/tb_isp_frame_sched.sv
// Frame-table bench for isp_frame_sched on a scaled 8x4 frame, with a
// scoreboard queue for the per-frame motion verdicts.
module tb_isp_frame_sched;

  localparam int unsigned H_ACT      = 8;
  localparam int unsigned V_ACT      = 4;
  localparam int unsigned REF_PERIOD = 4;
  localparam int unsigned MOTION_THR = 20;
  localparam int unsigned CNT_W      = 5;
  localparam int          NVEC       = 25;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             enable;
  logic             diff_valid;
  logic [CNT_W-1:0] motion_cnt;
  logic             motion_flag;
  logic [15:0]      frame_cnt;
  logic             geom_err;

  isp_frame_sched_if bus ();

  isp_frame_sched #(
    .H_ACT      (H_ACT),
    .V_ACT      (V_ACT),
    .REF_PERIOD (REF_PERIOD),
    .MOTION_THR (MOTION_THR),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .enable      (enable),
    .bus         (bus),
    .diff_valid  (diff_valid),
    .motion_cnt  (motion_cnt),
    .motion_flag (motion_flag),
    .frame_cnt   (frame_cnt),
    .geom_err    (geom_err)
  );

  always #5 sys_clk = ~sys_clk;

  // One input frame and what the scheduler must show for it; motion fields
  // are the verdict this frame produces one post_vsync later.
  typedef struct {
    int en; int drop; int lines; int short_line; int ones; int rst_at;
    int bank; int dv; int fcnt; int gerr; int wr; int rd; int mcnt; int mflag;
  } frame_vec_t;

  typedef struct { int mcnt; int mflag; } motion_exp_t;

  frame_vec_t  vecs [NVEC];
  motion_exp_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen, rd_seen;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cyc();
    #1;
    wr_seen += int'(bus.ref_wr_en);
    rd_seen += int'(bus.ref_rd_en);
    @(negedge sys_clk);
  endtask

  task automatic checkMotion(input string tag);
    motion_exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s motion scoreboard: got a verdict, expected none queued", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, " motion_cnt"}, int'(motion_cnt), e.mcnt);
      checkOutput({tag, " motion_flag"}, int'(motion_flag), e.mflag);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ref_wr_en"}, int'(bus.ref_wr_en), 0);
    checkOutput({tag, " ref_rd_en"}, int'(bus.ref_rd_en), 0);
    checkOutput({tag, " ref_bank"}, int'(bus.ref_bank), 0);
    checkOutput({tag, " ref_frame_start"}, int'(bus.ref_frame_start), 0);
    checkOutput({tag, " diff_valid"}, int'(diff_valid), 0);
    checkOutput({tag, " motion_cnt"}, int'(motion_cnt), 0);
    checkOutput({tag, " motion_flag"}, int'(motion_flag), 0);
    checkOutput({tag, " frame_cnt"}, int'(frame_cnt), 0);
    checkOutput({tag, " geom_err"}, int'(geom_err), 0);
  endtask

  task automatic applyStimulus(input frame_vec_t v, input int idx);
    string tag;
    int    pix;
    tag = $sformatf("f%0d", idx + 1);
    pix = 0;
    enable  = v.en[0];
    wr_seen = 0;
    rd_seen = 0;

    bus.pre_vsync = 1'b1;
    cyc();
    checkOutput({tag, " ref_frame_start"}, int'(bus.ref_frame_start), 1);
    checkOutput({tag, " ref_bank"}, int'(bus.ref_bank), v.bank);
    checkOutput({tag, " diff_valid"}, int'(diff_valid), v.dv);
    checkOutput({tag, " frame_cnt"}, int'(frame_cnt), v.fcnt);
    checkOutput({tag, " geom_err"}, int'(geom_err), v.gerr);
    cyc();
    bus.pre_vsync  = 1'b0;
    bus.post_vsync = 1'b1;
    checkOutput({tag, " ref_frame_start width"}, int'(bus.ref_frame_start), 0);
    cyc();
    bus.post_vsync = 1'b0;
    #1 checkMotion(tag);
    cyc();

    for (int l = 0; l < v.lines; l++) begin
      int npix;
      npix = (l == v.short_line) ? int'(H_ACT) - 1 : int'(H_ACT);
      if (l == 1 && v.drop != 0) enable = 1'b0;
      for (int p = 0; p < npix; p++) begin
        if (v.rst_at == pix) begin
          sys_rst = 1'b1;
          cyc();
          sys_rst = 1'b0;
          #1 checkAllZero({tag, " after reset"});
          wr_seen = 0;
          rd_seen = 0;
          sb.delete();
          sb.push_back('{0, 0});
        end
        bus.pre_href   = 1'b1;
        bus.pre_wr_en  = 1'b1;
        bus.post_wr_en = 1'b1;
        bus.post_1bit  = (pix < v.ones);
        pix++;
        cyc();
      end
      bus.pre_href   = 1'b0;
      bus.pre_wr_en  = 1'b0;
      bus.post_wr_en = 1'b0;
      bus.post_1bit  = 1'b0;
      cyc();
      cyc();
    end

    checkOutput({tag, " ref_wr_en count"}, wr_seen, v.wr);
    checkOutput({tag, " ref_rd_en count"}, rd_seen, v.rd);
    if (v.rst_at < 0) sb.push_back('{v.mcnt, v.mflag});
  endtask

  initial begin
    sys_rst        = 1'b1;
    enable         = 1'b0;
    bus.pre_vsync  = 1'b0;
    bus.pre_href   = 1'b0;
    bus.pre_wr_en  = 1'b0;
    bus.post_vsync = 1'b0;
    bus.post_wr_en = 1'b0;
    bus.post_1bit  = 1'b0;
    wr_seen        = 0;
    rd_seen        = 0;

    //            en dr ln sh ones rst  bank dv fcnt gerr wr  rd  mcnt flag
    vecs = '{
      '{1, 0, 4, -1, 25, -1,  0, 0,  1, 0, 32,  0, 25, 0},   // PRIME
      '{1, 0, 4, -1, 25, -1,  1, 1,  2, 0,  0, 32, 25, 1},   // RUN
      '{1, 0, 4, -1, 15, -1,  1, 1,  3, 0,  0, 32, 15, 0},
      '{1, 0, 4, -1, 20, -1,  1, 1,  4, 0,  0, 32, 20, 1},   // threshold exactly
      '{1, 0, 4, -1, 19, -1,  1, 1,  5, 0, 32, 32, 19, 0},   // REFRESH
      '{1, 0, 4, -1, 32, -1,  0, 1,  6, 0,  0, 32, 31, 1},   // saturation
      '{1, 0, 4, -1,  0, -1,  0, 1,  7, 0,  0, 32,  0, 0},
      '{1, 0, 4, -1, 22, -1,  0, 1,  8, 0,  0, 32, 22, 1},
      '{1, 0, 4, -1, 21, -1,  0, 1,  9, 0, 32, 32, 21, 1},   // REFRESH
      '{1, 0, 4, -1, 10, -1,  1, 1, 10, 0,  0, 32, 10, 0},
      '{1, 1, 4, -1, 25, -1,  1, 1, 11, 0,  0, 32, 25, 1},   // enable drops mid-frame
      '{0, 0, 4, -1, 25, -1,  1, 0, 11, 0,  0,  0, 25, 0},   // IDLE
      '{0, 0, 4, -1, 25, -1,  1, 0, 11, 0,  0,  0, 25, 0},
      '{1, 0, 4,  1, 25, -1,  1, 0,  1, 0, 31,  0, 25, 0},   // PRIME, short line
      '{1, 0, 4, -1, 25, -1,  1, 0,  2, 1, 32,  0, 25, 0},   // PRIME repeated
      '{1, 0, 4, -1, 25, -1,  0, 1,  3, 0,  0, 32, 25, 1},
      '{1, 0, 0, -1,  0, -1,  0, 1,  4, 0,  0,  0,  0, 0},   // no lines
      '{1, 0, 4, -1, 20, -1,  0, 1,  5, 1,  0, 32, 20, 1},
      '{1, 0, 3, -1, 24, -1,  0, 1,  6, 0, 24, 24, 24, 1},   // REFRESH, 3 lines
      '{1, 0, 4, -1, 24, -1,  0, 1,  7, 1, 32, 32, 24, 1},   // REFRESH repeated
      '{1, 0, 4, -1,  5, -1,  1, 1,  8, 0,  0, 32,  5, 0},
      '{1, 0, 4, -1,  0, 12,  1, 1,  9, 0,  0,  0,  0, 0},   // reset mid-line
      '{1, 0, 4, -1, 25, -1,  0, 0,  1, 0, 32,  0, 25, 0},   // PRIME again
      '{1, 0, 4, -1, 25, -1,  1, 1,  2, 0,  0, 32, 25, 1},
      '{1, 0, 4, -1,  0, -1,  1, 1,  3, 0,  0, 32,  0, 0}
    };

    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1 checkAllZero("reset");
    sb.push_back('{0, 0});

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
    end

    bus.post_vsync = 1'b1;
    cyc();
    bus.post_vsync = 1'b0;
    #1 checkMotion("flush");
    cyc();
    checkOutput("scoreboard leftover", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
